// File: rtl/if_fetch_pkg.sv
// Shared constants and state type for the instruction-fetch stage.
package if_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] BUBBLE_IS = '0;

  typedef enum logic {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetch_st_e;
endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit little-endian words from a byte-wide
// memory port and hands {pc_o, is_o} to decode; is_o == 0 is a bubble.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MEM_AW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_e,
  input  logic [XLEN-1:0]   br_pc,
  input  logic              mem_busy,
  input  logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_a,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   is_o
);

  fetch_st_e       st;
  logic [XLEN-1:0] fpc, w;
  logic [2:0]      req_idx;
  logic            pend;
  logic [1:0]      pend_idx;
  logic [7:0]      b0, b1, b2;

  logic [XLEN-1:0] req_addr, fpc_nx4, word;
  logic            done;

  assign req_addr = fpc + {29'd0, req_idx};
  assign fpc_nx4  = fpc + 32'd4;
  assign word     = {mem_din, b2, b1, b0};
  assign done     = pend && (pend_idx == 2'd3);

  // req_idx[2] set means all four bytes of the word are already requested
  always_comb begin
    mem_rd = 1'b0;
    mem_a  = fpc[MEM_AW-1:0];
    if (!rst && st == FETCH && !req_idx[2] && !mem_busy) begin
      mem_rd = 1'b1;
      mem_a  = req_addr[MEM_AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      req_idx  <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
      st       <= FETCH;
      b0       <= '0;
      b1       <= '0;
      b2       <= '0;
      w        <= '0;
      is_o     <= BUBBLE_IS;
      pc_o     <= '0;
    end else if (br_e) begin
      // a byte requested this cycle still goes out; clearing pend drops its data
      fpc     <= br_pc;
      req_idx <= '0;
      pend    <= 1'b0;
      st      <= FETCH;
      is_o    <= BUBBLE_IS;
      pc_o    <= '0;
    end else begin
      pend <= mem_rd;
      if (mem_rd) begin
        req_idx  <= req_idx + 3'd1;
        pend_idx <= req_idx[1:0];
      end
      if (pend) begin
        case (pend_idx)
          2'd0:    b0 <= mem_din;
          2'd1:    b1 <= mem_din;
          2'd2:    b2 <= mem_din;
          default: ;
        endcase
      end

      if (done && !stall_i) begin
        is_o    <= word;
        pc_o    <= fpc_nx4;
        fpc     <= fpc_nx4;
        req_idx <= '0;
      end else if (done) begin
        w  <= word;
        st <= FULL;
      end else if (st == FULL && !stall_i) begin
        is_o    <= w;
        pc_o    <= fpc_nx4;
        fpc     <= fpc_nx4;
        req_idx <= '0;
        st      <= FETCH;
      end else if (!stall_i) begin
        is_o <= BUBBLE_IS;
        pc_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table for the corner cases, then
// random traffic compared against a byte-queue reference model.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, stall_i, br_e, mem_busy, mem_rd;
  logic [31:0] br_pc, mem_a, pc_o, is_o;
  logic [7:0]  mem_din;

  int nchk = 0;
  int nerr = 0;

  if_fetch #(.RESET_PC(RESET_PC), .MEM_AW(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_e(br_e), .br_pc(br_pc),
    .mem_busy(mem_busy), .mem_din(mem_din), .mem_rd(mem_rd), .mem_a(mem_a),
    .pc_o(pc_o), .is_o(is_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memb(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'd0: return 8'h13;
      32'd1: return 8'h05;
      32'd2: return 8'hA0;
      32'd3: return 8'h00;
      default: ;
    endcase
    h = a * 32'h9E3779B1;
    return h[31:24] ^ a[7:0];
  endfunction

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {memb(a + 32'd3), memb(a + 32'd2), memb(a + 32'd1), memb(a)};
  endfunction

  // memory answers one cycle after a request; garbage otherwise
  always @(posedge clk) mem_din <= mem_rd ? memb(mem_a) : 8'($urandom);

  typedef struct {
    logic        rst, stall, br, busy;
    logic [31:0] br_pc;
    logic        rd, ca;
    logic [31:0] a, is, pc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, s, b, y, input logic [31:0] bp,
                     input logic rd, ca, input logic [31:0] a, is, pc);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.busy = y; v.br_pc = bp;
    v.rd = rd; v.ca = ca; v.a = a; v.is = is; v.pc = pc;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: counts requested bytes, queues returned bytes
  logic [31:0] m_fpc, m_paddr, m_held, m_is, m_pc;
  int          m_issued;
  bit          m_pend, m_full;
  logic [7:0]  got[$];

  task automatic model_step(input bit rd, input logic [31:0] a);
    bit          old_pend;
    logic [31:0] old_paddr, wd;
    bit          deliv;
    old_pend = m_pend; old_paddr = m_paddr; deliv = 0; wd = '0;
    if (rst) begin
      m_fpc = RESET_PC; m_issued = 0; m_pend = 0; m_full = 0;
      got.delete(); m_is = 0; m_pc = 0;
    end else if (br_e) begin
      m_fpc = br_pc; m_issued = 0; m_pend = 0; m_full = 0;
      got.delete(); m_is = 0; m_pc = 0;
    end else begin
      if (rd) m_issued++;
      m_pend = rd; m_paddr = a;
      if (old_pend) begin
        got.push_back(memb(old_paddr));
        if (got.size() == 4) begin
          wd = {got[3], got[2], got[1], got[0]};
          got.delete();
          if (!stall_i) deliv = 1;
          else begin m_full = 1; m_held = wd; end
        end
      end else if (m_full && !stall_i) begin
        wd = m_held; m_full = 0; deliv = 1;
      end
      if (deliv) begin
        m_is = wd; m_pc = m_fpc + 32'd4; m_fpc = m_fpc + 32'd4; m_issued = 0;
      end else if (!stall_i) begin
        m_is = 0; m_pc = 0;
      end
    end
  endtask

  task automatic cycle(input bit use_tab, input vec_t v, input int idx);
    bit          e_rd;
    logic [31:0] e_a;
    rst = v.rst; stall_i = v.stall; br_e = v.br; mem_busy = v.busy; br_pc = v.br_pc;
    #1;
    e_rd = !rst && !m_full && (m_issued < 4) && !mem_busy;
    e_a  = e_rd ? m_fpc + 32'(m_issued) : m_fpc;
    if (use_tab) begin
      chk($sformatf("rd[%0d]", idx), {31'd0, mem_rd}, {31'd0, v.rd});
      if (v.ca) chk($sformatf("a[%0d]", idx), mem_a, v.a);
    end else begin
      chk($sformatf("rnd_rd[%0d]", idx), {31'd0, mem_rd}, {31'd0, e_rd});
      chk($sformatf("rnd_a[%0d]", idx), mem_a, e_a);
    end
    @(posedge clk);
    model_step(e_rd, e_a);
    #1;
    if (use_tab) begin
      chk($sformatf("is[%0d]", idx), is_o, v.is);
      chk($sformatf("pc[%0d]", idx), pc_o, v.pc);
    end else begin
      chk($sformatf("rnd_is[%0d]", idx), is_o, m_is);
      chk($sformatf("rnd_pc[%0d]", idx), pc_o, m_pc);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1; stall_i = 0; br_e = 0; mem_busy = 0; br_pc = 0;
    m_fpc = 0; m_paddr = 0; m_held = 0; m_is = 0; m_pc = 0;
    m_issued = 0; m_pend = 0; m_full = 0;

    //   rst s  b  y  br_pc         rd ca a              is                  pc
    add(1, 0, 0, 0, 0,            0, 0, 0,            0,                  0);
    add(1, 0, 0, 0, 0,            0, 1, 0,            0,                  0);
    // reset fetch
    add(0, 0, 0, 0, 0,            1, 1, 0,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 1,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 2,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 3,            0,                  0);
    add(0, 0, 0, 0, 0,            0, 1, 0,            32'h00A00513,       4);
    add(0, 0, 0, 0, 0,            1, 1, 4,            0,                  0);
    // stall across the completion edge
    add(0, 0, 0, 0, 0,            1, 1, 5,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 6,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 7,            0,                  0);
    add(0, 1, 0, 0, 0,            0, 1, 4,            0,                  0);
    add(0, 1, 0, 0, 0,            0, 1, 4,            0,                  0);
    add(0, 1, 0, 0, 0,            0, 1, 4,            0,                  0);
    add(0, 0, 0, 0, 0,            0, 1, 4,            memw(4),            8);
    add(0, 0, 0, 0, 0,            1, 1, 8,            0,                  0);
    // busy over the byte-2 slot
    add(0, 0, 0, 0, 0,            1, 1, 9,            0,                  0);
    add(0, 0, 0, 1, 0,            0, 1, 8,            0,                  0);
    add(0, 0, 0, 1, 0,            0, 1, 8,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 10,           0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 11,           0,                  0);
    add(0, 0, 0, 0, 0,            0, 1, 8,            memw(8),            12);
    // flush mid-fetch
    add(0, 0, 0, 0, 0,            1, 1, 12,           0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 13,           0,                  0);
    add(0, 0, 1, 0, 32'h100,      1, 1, 14,           0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h100,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h101,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h102,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h103,      0,                  0);
    add(0, 0, 0, 0, 0,            0, 1, 32'h100,      memw(32'h100),      32'h104);
    // redirect with stall on the completion edge
    add(0, 0, 0, 0, 0,            1, 1, 32'h104,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h105,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h106,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h107,      0,                  0);
    add(0, 1, 1, 0, 32'h200,      0, 1, 32'h104,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h200,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h201,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h202,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h203,      0,                  0);
    add(0, 0, 0, 0, 0,            0, 1, 32'h200,      memw(32'h200),      32'h204);
    // address wrap, then reset during the byte-1 request
    add(0, 0, 1, 0, 32'hFFFFFFFC, 1, 1, 32'h204,      0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'hFFFFFFFC, 0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'hFFFFFFFD, 0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'hFFFFFFFE, 0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 32'hFFFFFFFF, 0,                  0);
    add(0, 0, 0, 0, 0,            0, 1, 32'hFFFFFFFC, memw(32'hFFFFFFFC), 0);
    add(0, 0, 0, 0, 0,            1, 1, 0,            0,                  0);
    add(1, 0, 0, 0, 0,            0, 1, 0,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 0,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 1,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 2,            0,                  0);
    add(0, 0, 0, 0, 0,            1, 1, 3,            0,                  0);
    add(0, 0, 0, 0, 0,            0, 1, 0,            32'h00A00513,       4);

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) cycle(1'b1, tv[i], i);

    for (int i = 0; i < 3000; i++) begin
      v.rst   = (i == 0) || ($urandom % 64 == 0);
      v.br    = ($urandom % 12 == 0);
      case ($urandom % 3)
        0:       v.br_pc = $urandom;
        1:       v.br_pc = 32'hFFFFFFF8 + ($urandom % 8);
        default: v.br_pc = $urandom % 32'h400;
      endcase
      v.stall = ($urandom % 4 == 0);
      v.busy  = ($urandom % 4 == 0);
      v.rd = 0; v.ca = 0; v.a = 0; v.is = 0; v.pc = 0;
      cycle(1'b0, v, i);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
